// File: rtl/cv_bram_pkg.sv
// Package: cv_bram_pkg
// Shared constants and the FSM state encoding for the CV BRAM strobe-write
// protocol. Imported by the responder, its interface, and anything else that
// speaks the protocol.
//   DATA_W      data word width
//   ADDR_W      address width, memory depth is 2**ADDR_W
//   ADDR_MAX    last writable address; anything above it is rejected
//   MIN_STROBE  cycles cs&wbit must stay high before a write is committed
package cv_bram_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 14;
  localparam logic [ADDR_W-1:0] ADDR_MAX = 14'h3FFE;
  localparam int MIN_STROBE = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STROBE   = 2'd1,
    COMMIT   = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  // Address the sequence tracker expects after a commit to addr.
  function automatic logic [ADDR_W-1:0] next_seq_addr(input logic [ADDR_W-1:0] addr);
    return (addr == ADDR_MAX) ? '0 : addr + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/cv_bram_responder_if.sv
// Interface: cv_bram_responder_if
// Bundles the strobe-write, readback and status signals between an initiator
// (master) and the BRAM responder (slave).
//   cs, wbit, waddress, wdata   write strobe from the initiator
//   rd_en, raddr                read request
//   rdata, rvalid               read response, one cycle after rd_en
//   wack, werr                  write committed / strobe rejected pulses
//   wr_count                    saturating count of committed writes
//   seq_err                     address-sequence break pulse
interface cv_bram_responder_if;
  import cv_bram_pkg::*;

  logic              cs;
  logic              wbit;
  logic [ADDR_W-1:0] waddress;
  logic [DATA_W-1:0] wdata;
  logic              rd_en;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              wack;
  logic              werr;
  logic [31:0]       wr_count;
  logic              seq_err;

  modport master (
    output cs, wbit, waddress, wdata, rd_en, raddr,
    input  rdata, rvalid, wack, werr, wr_count, seq_err
  );

  modport slave (
    input  cs, wbit, waddress, wdata, rd_en, raddr,
    output rdata, rvalid, wack, werr, wr_count, seq_err
  );

endinterface

// File: rtl/cv_bram_mem.sv
// Module: cv_bram_mem
// Simple dual-port RAM, 2**ADDR_W x DATA_W: one write port and one registered
// read port. A read and write to the same address in one cycle returns the old
// word (read-first). The read register clears on srst and holds when re is low;
// the array itself is never cleared.
//   clk, srst        clock, synchronous active-high reset of the read register
//   we, waddr, wdata write port
//   re, raddr        read request
//   rdata            read data, valid the cycle after re
module cv_bram_mem #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/cv_bram_responder.sv
// Module: cv_bram_responder
// Target side of the CV BRAM strobe-write protocol. A strobe is a run of
// cycles with cs&wbit high; once it has lasted MIN_STROBE cycles with steady
// address/data, exactly one write is committed to the BRAM. Runt strobes,
// strobes whose address/data move, and addresses above ADDR_MAX are rejected
// with a werr pulse.
//   clk, rst   single clock, synchronous active-high reset
//   bus        cv_bram_responder_if.slave: strobe inputs, read port,
//              wack/werr pulses, wr_count, seq_err
// Optional feature: define CV_BRAM_SEQ_CHECK_EN to enable the address-sequence
// tracker driving seq_err; otherwise seq_err is tied low.
module cv_bram_responder
  import cv_bram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  cv_bram_responder_if.slave   bus
);

  localparam int CNT_W = $clog2(MIN_STROBE + 1);
  // Count value on the last strobe cycle needed before committing.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_STROBE - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              wack_reg, wack_next;
  logic              werr_reg, werr_next;
  logic [31:0]       wr_count_reg;
  logic              rvalid_reg;
  logic [DATA_W-1:0] rdata_w;

  logic strobe;
  logic commit_ok;
  logic mem_we;

  assign strobe    = bus.cs & bus.wbit;
  assign commit_ok = (state_reg == COMMIT) && (addr_reg <= ADDR_MAX);
  // Reset landing on the commit cycle also suppresses the write.
  assign mem_we    = commit_ok & ~rst;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    wack_next  = 1'b0;
    werr_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (strobe) begin
          addr_next  = bus.waddress;
          data_next  = bus.wdata;
          cnt_next   = CNT_W'(1);
          state_next = (MIN_STROBE <= 1) ? COMMIT : STROBE;
        end
      end
      STROBE: begin
        if (!strobe) begin
          // Reaching MIN_STROBE leaves this state, so any drop here is a runt.
          werr_next  = 1'b1;
          state_next = IDLE;
        end else if ((bus.waddress != addr_reg) || (bus.wdata != data_reg)) begin
          werr_next  = 1'b1;
          state_next = WAIT_REL;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_LAST) begin
            state_next = COMMIT;
          end
        end
      end
      COMMIT: begin
        wack_next  = commit_ok;
        werr_next  = ~commit_ok;
        state_next = WAIT_REL;
      end
      WAIT_REL: begin
        if (!bus.cs) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
      wack_reg     <= 1'b0;
      werr_reg     <= 1'b0;
      wr_count_reg <= '0;
      rvalid_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      wack_reg   <= wack_next;
      werr_reg   <= werr_next;
      rvalid_reg <= bus.rd_en;
      if (commit_ok && (wr_count_reg != 32'hFFFF_FFFF)) begin
        wr_count_reg <= wr_count_reg + 32'd1;
      end
    end
  end

  cv_bram_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .srst  (rst),
    .we    (mem_we),
    .waddr (addr_reg),
    .wdata (data_reg),
    .re    (bus.rd_en),
    .raddr (bus.raddr),
    .rdata (rdata_w)
  );

`ifdef CV_BRAM_SEQ_CHECK_EN
  logic [ADDR_W-1:0] exp_addr_reg;
  logic              seq_err_reg;

  // Registered on the commit edge so the pulse lines up with wack.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_addr_reg <= '0;
      seq_err_reg  <= 1'b0;
    end else begin
      seq_err_reg <= 1'b0;
      if (commit_ok) begin
        seq_err_reg  <= (addr_reg != exp_addr_reg);
        exp_addr_reg <= next_seq_addr(addr_reg);
      end
    end
  end

  assign bus.seq_err = seq_err_reg;
`else
  assign bus.seq_err = 1'b0;
`endif

  assign bus.rdata    = rdata_w;
  assign bus.rvalid   = rvalid_reg;
  assign bus.wack     = wack_reg;
  assign bus.werr     = werr_reg;
  assign bus.wr_count = wr_count_reg;

endmodule

// File: tb/tb_cv_bram_responder.sv
// Testbench: tb_cv_bram_responder
// Directed table of strobe transactions, hand-written multi-cycle corner cases
// (reset mid-strobe, same-cycle read/write), and randomized strobes checked
// against a transaction-level model of the write rules.
module tb_cv_bram_responder;
  import cv_bram_pkg::*;

  localparam int MAXA = 16'h3FFE;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cv_bram_responder_if bus();

  cv_bram_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model
  logic [63:0] mdl_mem [int];
  int          wq[$];
  longint      mdl_count;
  int          mdl_exp_addr;

  typedef struct {
    int          addr;
    logic [63:0] data;
    int          len;
    int          chg;
    int          exp_wack;
    int          exp_werr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cs = 1'b0; bus.wbit = 1'b0; bus.waddress = '0; bus.wdata = '0;
    bus.rd_en = 1'b0; bus.raddr = '0;
  endtask

  task automatic model_reset();
    mdl_count = 0;
    mdl_exp_addr = 0;
  endtask

  // Outcome of one strobe by the write rules; returns expected seq_err.
  task automatic model_txn(input int addr, input logic [63:0] data, input int len, input int chg,
                           output int e_wack, output int e_werr, output int e_seq);
    e_wack = 0; e_werr = 0; e_seq = 0;
    if (chg >= 1 && chg < MIN_STROBE && chg < len) e_werr = 1;
    else if (len < MIN_STROBE) e_werr = 1;
    else if (addr > MAXA) e_werr = 1;
    else begin
      e_wack = 1;
      if (!mdl_mem.exists(addr)) wq.push_back(addr);
      mdl_mem[addr] = data;
      if (mdl_count < 64'hFFFF_FFFF) mdl_count++;
`ifdef CV_BRAM_SEQ_CHECK_EN
      e_seq = (addr != mdl_exp_addr) ? 1 : 0;
`endif
      mdl_exp_addr = (addr == MAXA) ? 0 : addr + 1;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
    chk("rst_rdata", bus.rdata, 64'd0);
    chk("rst_rvalid", {63'd0, bus.rvalid}, 64'd0);
    chk("rst_wack", {63'd0, bus.wack}, 64'd0);
    chk("rst_werr", {63'd0, bus.werr}, 64'd0);
    chk("rst_wr_count", {32'd0, bus.wr_count}, 64'd0);
    chk("rst_seq_err", {63'd0, bus.seq_err}, 64'd0);
  endtask

  // Drive one strobe of len cycles (data inverted on cycle chg), then idle,
  // counting the response pulses.
  task automatic strobe_txn(input int addr, input logic [63:0] data, input int len, input int chg,
                            output int n_wack, output int n_werr, output int n_seq, output int lat,
                            output int n_both, output int n_lone);
    int n;
    n = 0; n_wack = 0; n_werr = 0; n_seq = 0; lat = -1; n_both = 0; n_lone = 0;
    for (int c = 0; c < len + 8; c++) begin
      if (c < len) begin
        bus.cs = 1'b1; bus.wbit = 1'b1;
        bus.waddress = addr[ADDR_W-1:0];
        bus.wdata = (c == chg) ? ~data : data;
      end else begin
        bus.cs = 1'b0; bus.wbit = 1'b0;
      end
      step();
      n++;
      if (bus.wack) begin
        n_wack++;
        if (lat < 0) lat = n;
      end
      if (bus.werr) n_werr++;
      if (bus.seq_err) n_seq++;
      if (bus.wack && bus.werr) n_both++;
      if (bus.seq_err && !bus.wack) n_lone++;
    end
  endtask

  task automatic run_txn(input int addr, input logic [63:0] data, input int len, input int chg,
                         output int a_wack, output int a_werr);
    int e_wack, e_werr, e_seq, n_seq, lat, n_both, n_lone;
    model_txn(addr, data, len, chg, e_wack, e_werr, e_seq);
    strobe_txn(addr, data, len, chg, a_wack, a_werr, n_seq, lat, n_both, n_lone);
    $display("txn addr=%h len=%0d chg=%0d wack=%0d werr=%0d seq_err=%0d wr_count=%0d",
             addr, len, chg, a_wack, a_werr, n_seq, bus.wr_count);
    chk("txn_wack", a_wack, e_wack);
    chk("txn_werr", a_werr, e_werr);
    chk("txn_seq_err", n_seq, e_seq);
    chk("txn_wr_count", {32'd0, bus.wr_count}, mdl_count);
    chk("txn_wack_werr_overlap", n_both, 0);
    chk("txn_seq_err_without_wack", n_lone, 0);
    if (e_wack == 1) chk("txn_wack_latency", lat, MIN_STROBE + 1);
  endtask

  task automatic read_chk(input int addr, input logic [63:0] exp);
    bus.rd_en = 1'b1;
    bus.raddr = addr[ADDR_W-1:0];
    step();
    $display("read addr=%h rdata=%h rvalid=%0d", addr, bus.rdata, bus.rvalid);
    chk("read_rvalid", {63'd0, bus.rvalid}, 64'd1);
    chk("read_rdata", bus.rdata, exp);
    bus.rd_en = 1'b0;
    bus.raddr = bus.raddr ^ 14'h1;
    step();
    chk("read_rvalid_low", {63'd0, bus.rvalid}, 64'd0);
    chk("read_rdata_hold", bus.rdata, exp);
  endtask

  initial begin
    int aw, ae;
    logic [63:0] v1, v2, v3;

    vecs[0] = '{addr: 0,       data: 64'hAABBCCDDEEFF9988, len: 4,  chg: -1, exp_wack: 1, exp_werr: 0};
    vecs[1] = '{addr: 5,       data: 64'h5555_0000_1111_2222, len: 3, chg: -1, exp_wack: 1, exp_werr: 0};
    vecs[2] = '{addr: 5,       data: 64'hDEAD_BEEF_0000_0005, len: 2, chg: -1, exp_wack: 0, exp_werr: 1};
    vecs[3] = '{addr: 16'h3FFF, data: 64'h0123_4567_89AB_CDEF, len: 4, chg: -1, exp_wack: 0, exp_werr: 1};
    vecs[4] = '{addr: 16'h3FFE, data: 64'hFEDC_BA98_7654_3210, len: 4, chg: -1, exp_wack: 1, exp_werr: 0};
    vecs[5] = '{addr: 6,       data: 64'h6666_6666_6666_6666, len: 20, chg: -1, exp_wack: 1, exp_werr: 0};
    vecs[6] = '{addr: 7,       data: 64'h7777_0000_7777_0000, len: 5, chg: 1,  exp_wack: 0, exp_werr: 1};
    vecs[7] = '{addr: 7,       data: 64'h7777_1111_7777_1111, len: 5, chg: 2,  exp_wack: 0, exp_werr: 1};
    vecs[8] = '{addr: 8,       data: 64'h8888_8888_8888_8888, len: 1, chg: -1, exp_wack: 0, exp_werr: 1};

    do_reset();

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].addr, vecs[i].data, vecs[i].len, vecs[i].chg, aw, ae);
      chk("vec_wack", aw, vecs[i].exp_wack);
      chk("vec_werr", ae, vecs[i].exp_werr);
    end
    read_chk(0, 64'hAABBCCDDEEFF9988);
    read_chk(5, 64'h5555_0000_1111_2222);
    read_chk(16'h3FFE, 64'hFEDC_BA98_7654_3210);
    read_chk(6, 64'h6666_6666_6666_6666);

    // Reset on the third strobe cycle: nothing is written.
    v1 = 64'h9999_0000_AAAA_0001;
    v2 = 64'h9999_0000_BBBB_0002;
    v3 = 64'h9999_0000_CCCC_0003;
    run_txn(9, v1, 4, -1, aw, ae);
    for (int c = 0; c < 3; c++) begin
      bus.cs = 1'b1; bus.wbit = 1'b1; bus.waddress = 14'd9; bus.wdata = v2;
      if (c == 2) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    model_reset();
    idle_inputs();
    $display("txn reset mid-strobe addr=9 wack=%0d werr=%0d wr_count=%0d", bus.wack, bus.werr, bus.wr_count);
    chk("midrst_rdata", bus.rdata, 64'd0);
    chk("midrst_rvalid", {63'd0, bus.rvalid}, 64'd0);
    chk("midrst_wack", {63'd0, bus.wack}, 64'd0);
    chk("midrst_werr", {63'd0, bus.werr}, 64'd0);
    chk("midrst_wr_count", {32'd0, bus.wr_count}, 64'd0);
    chk("midrst_seq_err", {63'd0, bus.seq_err}, 64'd0);
    aw = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.wack || bus.werr) aw++;
    end
    chk("midrst_no_pulse", aw, 0);
    read_chk(9, v1);

    // Read of addr 9 in the commit cycle returns the old word.
    begin
      int e_wack, e_werr, e_seq;
      model_txn(9, v3, 4, -1, e_wack, e_werr, e_seq);
      for (int c = 0; c < 4; c++) begin
        bus.cs = 1'b1; bus.wbit = 1'b1; bus.waddress = 14'd9; bus.wdata = v3;
        if (c == 3) begin
          bus.rd_en = 1'b1;
          bus.raddr = 14'd9;
        end
        step();
      end
      bus.rd_en = 1'b0;
      bus.cs = 1'b0; bus.wbit = 1'b0;
      $display("txn same-cycle rw addr=9 rdata=%h wack=%0d", bus.rdata, bus.wack);
      chk("rw_rdata_old", bus.rdata, v1);
      chk("rw_rvalid", {63'd0, bus.rvalid}, 64'd1);
      chk("rw_wack", {63'd0, bus.wack}, {63'd0, e_wack[0]});
      chk("rw_seq_err", {63'd0, bus.seq_err}, {63'd0, e_seq[0]});
      for (int c = 0; c < 4; c++) step();
      chk("rw_wr_count", {32'd0, bus.wr_count}, mdl_count);
      read_chk(9, v3);
    end

    // Address sequence, including the wrap after the last writable address.
    do_reset();
    foreach (vecs[i]) begin end
    begin
      int seq_addrs[7] = '{0, 1, 2, 3, 7, 16'h3FFE, 0};
      for (int i = 0; i < 7; i++) begin
        run_txn(seq_addrs[i], {32'hC0DE_0000, 32'(i)}, 3, -1, aw, ae);
      end
    end

    // Randomized strobes against the model.
    for (int i = 0; i < 50; i++) begin
      int sel, addr, len, chg;
      logic [63:0] data;
      sel = $urandom_range(0, 9);
      if (sel <= 6) addr = $urandom_range(0, 15);
      else if (sel == 7) addr = 16'h3FFE;
      else if (sel == 8) addr = 16'h3FFF;
      else addr = $urandom_range(0, 16383);
      len = ($urandom_range(0, 7) == 0) ? 12 : $urandom_range(1, 6);
      chg = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : -1;
      data = {$urandom, $urandom};
      run_txn(addr, data, len, chg, aw, ae);
      if (wq.size() > 0 && $urandom_range(0, 2) == 0) begin
        int ra;
        ra = wq[$urandom_range(0, wq.size() - 1)];
        read_chk(ra, mdl_mem[ra]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
